// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback queue: entry layout and
// the round-robin grant record used when only one queue slot is free.
package rf_wb_pkg;

  localparam int WB_AW = 3;
  localparam int WB_DW = 8;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Newest-first match of one read address against the pending queue entries
// and the registered write stage; the output stage is the oldest candidate.
module wb_fwd_lookup
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  wb_entry_t [DEPTH-1:0]           entries,
  input  logic [$clog2(DEPTH)-1:0]        head,
  input  logic [$clog2(DEPTH+1)-1:0]      count,
  input  logic                            out_we,
  input  logic [AW-1:0]                   out_addr,
  input  logic [DW-1:0]                   out_data,
  input  logic [AW-1:0]                   rd_addr,
  output logic                            hit,
  output logic [DW-1:0]                   data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] idx;

  // Walk oldest to newest so the last match wins, giving newest-first priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (out_we && (out_addr == rd_addr)) begin
      hit  = 1'b1;
      data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (entries[idx].addr == rd_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Merges ALU and load writebacks into one registered register-file write
// stream through a small FIFO, with forwarding of the newest pending value.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [AW-1:0]                 alu_addr,
  input  logic [DW-1:0]                 alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [AW-1:0]                 ld_addr,
  input  logic [DW-1:0]                 ld_data,
  output logic                          rf_we,
  output logic [AW-1:0]                 rf_waddr,
  output logic [DW-1:0]                 rf_wdata,
  input  logic [AW-1:0]                 rd_addr1,
  input  logic [AW-1:0]                 rd_addr2,
  output logic                          fwd_hit1,
  output logic [DW-1:0]                 fwd_data1,
  output logic                          fwd_hit2,
  output logic [DW-1:0]                 fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] ONE_FREE = CW'(DEPTH-1);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         alu_slot;
  grant_t                last_grant;
  logic                  alu_push;
  logic                  ld_push;
  logic                  pop;
  logic                  contended;

  // Credit comes only from count at the start of the cycle; a same-cycle pop frees nothing.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    contended = (count == ONE_FREE) && alu_valid && ld_valid;
    if (!rst) begin
      if (count < ONE_FREE) begin
        alu_ready = 1'b1;
        ld_ready  = 1'b1;
      end else if (count == ONE_FREE) begin
        if (ld_valid && (!alu_valid || (last_grant == GRANT_ALU))) begin
          ld_ready = 1'b1;
        end else if (alu_valid) begin
          alu_ready = 1'b1;
        end
      end
    end
  end

  assign alu_push = alu_valid && alu_ready;
  assign ld_push  = ld_valid && ld_ready;
  assign pop      = (count != '0);
  // The load entry takes the first free slot, so the ALU result is the younger one.
  assign alu_slot = tail + PW'(ld_push);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_grant <= GRANT_ALU;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= entries[head].addr;
        rf_wdata <= entries[head].data;
        head     <= head + PW'(1);
      end else begin
        rf_we <= 1'b0;
      end
      if (ld_push) begin
        entries[tail] <= '{addr: ld_addr, data: ld_data};
      end
      if (alu_push) begin
        entries[alu_slot] <= '{addr: alu_addr, data: alu_data};
      end
      tail  <= tail + PW'(ld_push) + PW'(alu_push);
      count <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
      if (contended) begin
        if (ld_push) begin
          last_grant <= GRANT_LD;
        end else begin
          last_grant <= GRANT_ALU;
        end
      end
    end
  end

  wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .entries  (entries),
    .head     (head),
    .count    (count),
    .out_we   (rf_we),
    .out_addr (rf_waddr),
    .out_data (rf_wdata),
    .rd_addr  (rd_addr1),
    .hit      (fwd_hit1),
    .data     (fwd_data1)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .entries  (entries),
    .head     (head),
    .count    (count),
    .out_we   (rf_we),
    .out_addr (rf_waddr),
    .out_data (rf_wdata),
    .rd_addr  (rd_addr2),
    .hit      (fwd_hit2),
    .data     (fwd_data2)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: a behavioural queue model acts as the
// scoreboard for readies, forwarding, count and the registered write stream.
module tb_rf_writeback_queue;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data2;
  logic [CW-1:0] count;

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wb_entry_t     mq[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  grant_t        m_last;
  int            n_cmp;
  int            n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void mfwd(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == ra) begin
        h = 1'b1;
        d = mq[i].data;
        return;
      end
    end
    if (m_we && (m_addr == ra)) begin
      h = 1'b1;
      d = m_data;
    end
  endfunction

  // One clock: drive at the falling edge, check combinational outputs, take the
  // rising edge, update the model, then check the registered write stage.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic          e_ar;
    logic          e_lr;
    logic          h;
    logic [DW-1:0] d;
    int            cnt;
    wb_entry_t     e;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ldd;
    rd_addr1  = r1;
    rd_addr2  = r2;
    #1;
    cnt  = mq.size();
    e_ar = 1'b0;
    e_lr = 1'b0;
    if (DEPTH - cnt >= 2) begin
      e_ar = 1'b1;
      e_lr = 1'b1;
    end else if (DEPTH - cnt == 1) begin
      if (lv && (!av || (m_last == GRANT_ALU))) e_lr = 1'b1;
      else if (av) e_ar = 1'b1;
    end
    chk("count", 32'(count), 32'(cnt));
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("ld_ready", 32'(ld_ready), 32'(e_lr));
    mfwd(r1, h, d);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", 32'(fwd_data1), 32'(d));
    mfwd(r2, h, d);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", 32'(fwd_data2), 32'(d));
    @(posedge clk);
    if (cnt > 0) begin
      e      = mq.pop_front();
      m_we   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if ((DEPTH - cnt == 1) && av && lv) begin
      if (e_lr) m_last = GRANT_LD;
      else      m_last = GRANT_ALU;
    end
    if (lv && e_lr) begin
      e.addr = la;
      e.data = ldd;
      mq.push_back(e);
    end
    if (av && e_ar) begin
      e.addr = aa;
      e.data = ad;
      mq.push_back(e);
    end
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
    chk("rf_wdata", 32'(rf_wdata), 32'(m_data));
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    step(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
  endtask

  // Asynchronous reset pulse between clock edges with the queue busy.
  task automatic rst_pulse(input logic [AW-1:0] r1);
    #2;
    alu_valid = 1'b1;
    ld_valid  = 1'b1;
    rd_addr1  = r1;
    rst       = 1'b1;
    #1;
    mq.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_last = GRANT_ALU;
    chk("rst_rf_we", 32'(rf_we), 32'(1'b0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_alu_ready", 32'(alu_ready), 32'(1'b0));
    chk("rst_ld_ready", 32'(ld_ready), 32'(1'b0));
    chk("rst_fwd_hit1", 32'(fwd_hit1), 32'(1'b0));
    chk("rst_rf_waddr", 32'(rf_waddr), 32'(0));
    chk("rst_rf_wdata", 32'(rf_wdata), 32'(0));
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_last    = GRANT_ALU;
    rst       = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    rd_addr1  = '0;
    rd_addr2  = '0;
    #1;
    rst       = 1'b1;
    alu_valid = 1'b1;
    ld_valid  = 1'b1;
    #1;
    chk("init_rf_we", 32'(rf_we), 32'(1'b0));
    chk("init_rf_waddr", 32'(rf_waddr), 32'(0));
    chk("init_rf_wdata", 32'(rf_wdata), 32'(0));
    chk("init_count", 32'(count), 32'(0));
    chk("init_alu_ready", 32'(alu_ready), 32'(1'b0));
    chk("init_ld_ready", 32'(ld_ready), 32'(1'b0));
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // single ALU write
    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7);
    idle(3'd3, 3'd7);
    idle(3'd3, 3'd7);
    idle(3'd3, 3'd0);

    // dual accept, same address: load ahead of ALU
    step(1'b1, 3'd5, 8'h22, 1'b1, 3'd5, 8'h11, 3'd5, 3'd3);
    idle(3'd5, 3'd3);
    idle(3'd5, 3'd3);
    idle(3'd5, 3'd3);
    idle(3'd5, 3'd0);

    // forwarding precedence: queue holds 0x33 then 0x44, output stage 0x55
    step(1'b1, 3'd2, 8'h55, 1'b0, 3'd0, 8'h00, 3'd2, 3'd7);
    step(1'b1, 3'd2, 8'h44, 1'b1, 3'd2, 8'h33, 3'd2, 3'd7);
    idle(3'd2, 3'd7);
    idle(3'd2, 3'd7);
    idle(3'd2, 3'd7);
    idle(3'd2, 3'd7);

    // register 0 via the load port
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h9E, 3'd0, 3'd1);
    idle(3'd0, 3'd1);
    idle(3'd0, 3'd1);

    // fill and round-robin arbitration with both sources always valid
    for (int i = 0; i < 10; i++) begin
      step(1'b1, AW'(i), DW'(8'h80 + i), 1'b1, AW'(i + 4), DW'(8'h40 + i), AW'(i), 3'd5);
    end

    // reset with entries pending, then restart from empty
    rst_pulse(3'd1);
    idle(3'd1, 3'd5);
    idle(3'd1, 3'd5);
    idle(3'd1, 3'd5);
    step(1'b1, 3'd6, 8'hC3, 1'b0, 3'd0, 8'h00, 3'd6, 3'd1);
    idle(3'd6, 3'd1);
    idle(3'd6, 3'd1);
    idle(3'd6, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
